kyber_keygen_sampler: RTL and testbench

//  Parametrised key-coefficient generator for the Baby-Kyber datapath; successor to the fixed 2x4 parallel-RNG key block.

---
 rtl/kyber_keygen_pkg.sv | 14 +
 rtl/keygen_lfsr.sv | 29 ++
 rtl/kyber_keygen_sampler.sv | 131 +++++++++++++
 tb/tb_kyber_keygen_sampler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_keygen_pkg.sv
// Shared types, LFSR taps and the CBD coefficient helper for the Baby-Kyber key sampler.
package kyber_keygen_pkg;

    typedef enum logic {MODE_UNIFORM, MODE_CBD} kg_mode_e;
    typedef enum logic {S_IDLE, S_GEN} kg_state_e;

    localparam logic [31:0] LFSR32_TAPS = 32'h80200003;

    // Centred-binomial difference mapped into [0, q-1].
    function automatic int cbd_coef(input int a, input int b, input int q);
        return (a >= b) ? (a - b) : (q - (b - a));
    endfunction

endpackage

// File: rtl/keygen_lfsr.sv
// Galois right-shift LFSR with synchronous load (priority over step); a zero load maps to 1.
module keygen_lfsr #(
    parameter int           W       = 32,
    parameter logic [W-1:0] TAPS    = W'(32'h80200003),
    parameter logic [W-1:0] RST_VAL = W'(1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_VAL;
        end else if (load_i) begin
            state_q <= (load_val_i == '0) ? W'(1) : load_val_i;
        end else if (step_i) begin
            state_q <= state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/kyber_keygen_sampler.sv
// Fills a K x N coefficient array mod Q from one LFSR, in uniform (rejection) or CBD(ETA) mode.
// States: S_IDLE | waiting for start, keys held; S_GEN | one candidate sampled per cycle.
module kyber_keygen_sampler
    import kyber_keygen_pkg::*;
#(
    parameter int                K        = 2,
    parameter int                N        = 4,
    parameter int                Q        = 17,
    parameter int                COEF_W   = 32,
    parameter int                ETA      = 1,
    parameter int                LFSR_W   = 32,
    parameter logic [LFSR_W-1:0] SEED_RST = LFSR_W'(1),
    parameter int                MAX_CYC  = 4*K*N
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                seed_load_i,
    input  logic [LFSR_W-1:0]                   seed_i,
    input  logic                                start_i,
    input  logic                                mode_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                valid_o,
    output logic                                err_o,
    output logic [K-1:0][N-1:0][COEF_W-1:0]     keys_o
);

    localparam int B  = $clog2(Q);
    localparam int AW = B + 1;
    localparam int KN = K * N;
    localparam int IW = (KN > 1) ? $clog2(KN) : 1;
    localparam int CW = $clog2(MAX_CYC + 1);

    kg_state_e                   state_q;
    kg_mode_e                    mode_q;
    logic [IW-1:0]               idx_q;
    logic [CW-1:0]               cyc_q;
    logic [KN-1:0][COEF_W-1:0]   keys_q;
    logic                        busy_q, done_q, valid_q, err_q;

    logic [LFSR_W-1:0]           lfsr_s;
    logic                        lfsr_unused;
    logic [AW-1:0]               cand_u;
    logic [AW-1:0]               coef_d;
    logic                        accept_d;
    int                          pop_a, pop_b;

    keygen_lfsr #(
        .W       (LFSR_W),
        .TAPS    (LFSR_W'(LFSR32_TAPS)),
        .RST_VAL (SEED_RST)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     ((state_q == S_IDLE) && seed_load_i),
        .load_val_i (seed_i),
        .step_i     (state_q == S_GEN),
        .state_o    (lfsr_s)
    );

    // Only the low candidate bits feed the sampler; the rest just advance the sequence.
    assign lfsr_unused = ^lfsr_s;

    always_comb begin
        pop_a    = $countones(lfsr_s[ETA-1:0]);
        pop_b    = $countones(lfsr_s[2*ETA-1:ETA]);
        cand_u   = {1'b0, lfsr_s[B-1:0]};
        coef_d   = cand_u;
        accept_d = (cand_u < AW'(Q));
        if (mode_q == MODE_CBD) begin
            coef_d   = AW'(cbd_coef(pop_a, pop_b, Q));
            accept_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_UNIFORM;
            idx_q   <= '0;
            cyc_q   <= '0;
            keys_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q  <= kg_mode_e'(mode_i);
                        idx_q   <= '0;
                        cyc_q   <= '0;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_GEN;
                    end
                end
                S_GEN: begin
                    cyc_q <= cyc_q + CW'(1);
                    if (accept_d) begin
                        keys_q[idx_q] <= COEF_W'(coef_d);
                        idx_q         <= idx_q + IW'(1);
                    end
                    // Completion wins over the budget on the very last allowed cycle.
                    if (accept_d && (idx_q == IW'(KN - 1))) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end else if (cyc_q == CW'(MAX_CYC - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign keys_o  = keys_q;

endmodule

// File: tb/tb_kyber_keygen_sampler.sv
// Directed bench for kyber_keygen_sampler: default instance plus a small-budget instance for aborts.
module tb_kyber_keygen_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        seed_load_a = 1'b0, start_a = 1'b0, mode_a = 1'b0;
    logic [31:0] seed_a = '0;
    logic        busy_a, done_a, valid_a, err_a;
    logic [1:0][3:0][31:0] keys_a;

    logic        seed_load_b = 1'b0, start_b = 1'b0, mode_b = 1'b0;
    logic [31:0] seed_b = '0;
    logic        busy_b, done_b, valid_b, err_b;
    logic [1:0][7:0][31:0] keys_b;

    kyber_keygen_sampler dut_a (
        .clk(clk), .rst_n(rst_n), .seed_load_i(seed_load_a), .seed_i(seed_a),
        .start_i(start_a), .mode_i(mode_a), .busy_o(busy_a), .done_o(done_a),
        .valid_o(valid_a), .err_o(err_a), .keys_o(keys_a)
    );

    kyber_keygen_sampler #(.K(2), .N(8), .Q(2), .MAX_CYC(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .seed_load_i(seed_load_b), .seed_i(seed_b),
        .start_i(start_b), .mode_i(mode_b), .busy_o(busy_b), .done_o(done_b),
        .valid_o(valid_b), .err_o(err_b), .keys_o(keys_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the default instance (K=2, N=4, Q=17, ETA=1, MAX_CYC=32).
    logic [31:0] m_s = 32'h1;
    int          m_keys[8];
    logic [31:0] lst[$];

    function automatic logic [31:0] lfsr_nxt(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic model_run(input bit m, output int gen, output bit ok);
        int idx = 0;
        gen = 0;
        ok  = 1'b0;
        while (gen < 32 && !ok) begin
            int  c;
            bit  acc;
            if (m) begin
                int a = int'(m_s[0]);
                int b = int'(m_s[1]);
                c   = (a >= b) ? (a - b) : (17 - (b - a));
                acc = 1'b1;
            end else begin
                c   = int'(m_s[4:0]);
                acc = (c < 17);
            end
            if (acc) begin
                m_keys[idx] = c;
                idx++;
            end
            m_s = lfsr_nxt(m_s);
            gen++;
            if (idx == 8) ok = 1'b1;
        end
    endtask

    task automatic run_a(input bit m, input bit ld, input logic [31:0] sd,
                         input bit disturb, input string tag);
        int  gen_exp;
        bit  ok_exp;
        int  cnt = 0;
        bit  got = 1'b0;
        lst.delete();
        if (ld) m_s = (sd == 32'h0) ? 32'h1 : sd;
        model_run(m, gen_exp, ok_exp);
        mode_a = m; seed_a = sd; seed_load_a = ld; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; seed_load_a = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (disturb) begin
                if (t == 2) begin
                    start_a = 1'b1; seed_load_a = 1'b1; seed_a = 32'hDEADBEEF; mode_a = ~m;
                end else begin
                    start_a = 1'b0; seed_load_a = 1'b0;
                end
            end
            if (busy_a) begin
                lst.push_back(dut_a.lfsr_s);
                cnt++;
            end
            if (done_a) got = 1'b1;
        end
        check({tag, " done"}, 64'(got), 64'd1);
        check({tag, " gen_cycles"}, 64'(cnt), 64'(gen_exp));
        check({tag, " valid"}, 64'(valid_a), 64'(ok_exp));
        check({tag, " err"}, 64'(err_a), 64'(!ok_exp));
        for (int i = 0; i < 8; i++)
            check($sformatf("%s key%0d", tag, i), 64'(keys_a[i/4][i%4]), 64'(m_keys[i]));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done_a), 64'd0);
        check({tag, " lfsr_after"}, 64'(dut_a.lfsr_s), 64'(m_s));
    endtask

    initial begin : main
        int  cnt;
        bit  got;
        bit  saw_done;
        logic [7:0] exp_b;

        // 1. reset defaults
        repeat (2) @(negedge clk);
        check("rst keys_a", 64'(|keys_a), 64'd0);
        check("rst busy/done/valid/err", 64'({busy_a, done_a, valid_a, err_a}), 64'd0);
        check("rst lfsr", 64'(dut_a.lfsr_s), 64'h1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst outputs", 64'({busy_a, done_a, valid_a, err_a, busy_b, err_b}), 64'd0);
        check("post-rst keys_b", 64'(|keys_b), 64'd0);

        // 2. CBD seed 1, loaded together with start
        run_a(1'b1, 1'b1, 32'h1, 1'b0, "cbd1");
        check("cbd1 hand key00", 64'(keys_a[0][0]), 64'd1);
        check("cbd1 hand key01", 64'(keys_a[0][1]), 64'd0);
        check("cbd1 hand key02", 64'(keys_a[0][2]), 64'd16);
        check("cbd1 busy_cycles", 64'(lst.size()), 64'd8);
        if (lst.size() >= 3) begin
            check("cbd1 lfsr0", 64'(lst[0]), 64'h1);
            check("cbd1 lfsr1", 64'(lst[1]), 64'h80200003);
            check("cbd1 lfsr2", 64'(lst[2]), 64'hC0300002);
        end else begin
            check("cbd1 lfsr trace length", 64'(lst.size()), 64'd3);
        end

        // 3. uniform runs: seed 1, a seed forcing rejections, and one continuing the LFSR
        run_a(1'b0, 1'b1, 32'h1, 1'b0, "uni1");
        run_a(1'b0, 1'b1, 32'h0000_001F, 1'b0, "uni1f");
        run_a(1'b0, 1'b0, 32'h0, 1'b0, "uni_cont");
        for (int i = 0; i < 8; i++)
            check($sformatf("uni range key%0d", i), 64'(keys_a[i/4][i%4] < 32'd17), 64'd1);

        // zero seed behaves as seed 1
        run_a(1'b1, 1'b1, 32'h0, 1'b0, "cbd_seed0");
        check("cbd_seed0 key02", 64'(keys_a[0][2]), 64'd16);

        // 5. start/seed_load while busy are ignored
        run_a(1'b0, 1'b1, 32'h0000_001F, 1'b1, "uni_disturb");

        // 4. abort on the small-budget instance: Q=2 accepts all, K*N=16 exceeds 8 cycles
        mode_b = 1'b0; seed_b = 32'h1; seed_load_b = 1'b1; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; seed_load_b = 1'b0;
        cnt = 0; got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (busy_b) cnt++;
            if (done_b) got = 1'b1;
        end
        check("abort done", 64'(got), 64'd1);
        check("abort gen_cycles", 64'(cnt), 64'd8);
        check("abort err", 64'(err_b), 64'd1);
        check("abort valid", 64'(valid_b), 64'd0);
        exp_b = 8'b1101_1011;
        for (int i = 0; i < 8; i++)
            check($sformatf("abort key%0d", i), 64'(keys_b[0][i]), 64'(exp_b[i]));
        check("abort row1 untouched", 64'(|keys_b[1]), 64'd0);
        mode_b = 1'b1; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk);
        check("restart clears err", 64'(err_b), 64'd0);
        check("restart busy", 64'(busy_b), 64'd1);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (done_b) got = 1'b1;
        end
        check("second abort err", 64'({got, err_b, valid_b}), 64'b110);

        // 6. reset in the middle of a run
        mode_a = 1'b1; seed_a = 32'h1; seed_load_a = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; seed_load_a = 1'b0;
        cnt = 0;
        for (int t = 0; t < 20 && cnt < 3; t++) begin
            @(negedge clk);
            if (busy_a) cnt++;
        end
        check("midrst reached cycle 3", 64'(cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        check("midrst outputs", 64'({busy_a, done_a, valid_a, err_a}), 64'd0);
        check("midrst keys", 64'(|keys_a), 64'd0);
        check("midrst lfsr", 64'(dut_a.lfsr_s), 64'h1);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done_a) saw_done = 1'b1;
        check("midrst no done", 64'(saw_done), 64'd0);
        m_s = 32'h1;
        for (int i = 0; i < 8; i++) m_keys[i] = 0;
        run_a(1'b1, 1'b0, 32'h0, 1'b0, "post_midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
